// File: rtl/async_fifo_read_stream_if.sv
// FIFO read channel plus downstream valid/ready stream for the read-side consumer.
// master: the consumer block; slave: the FIFO and downstream logic around it.
interface async_fifo_read_stream_if #(
  parameter int FIFO_DATA_WIDTH = 32
);
  logic                       read_fifo_empty;
  logic                       read_fifo_pop;
  logic [FIFO_DATA_WIDTH-1:0] read_data;
  logic                       out_valid;
  logic                       out_ready;
  logic [FIFO_DATA_WIDTH-1:0] out_data;

  modport master (
    input  read_fifo_empty,
    input  read_data,
    input  out_ready,
    output read_fifo_pop,
    output out_valid,
    output out_data
  );

  modport slave (
    output read_fifo_empty,
    output read_data,
    output out_ready,
    input  read_fifo_pop,
    input  out_valid,
    input  out_data
  );
endinterface

// File: rtl/async_fifo_read_stream.sv
// Read-domain FIFO consumer: pops with credit accounting into a 2-entry buffer
// and presents the words as a valid/ready stream, with a popped-word counter.
module async_fifo_read_stream #(
  parameter int FIFO_DATA_WIDTH = 32,
  parameter int COUNT_WIDTH     = 32
) (
  input  logic                    read_clk,
  input  logic                    read_reset,
  input  logic                    read_enable,
  async_fifo_read_stream_if.master bus,
  output logic [COUNT_WIDTH-1:0]  pop_count
);

  logic [1:0]                 occ_r;
  logic                       inflight_r;
  logic                       valid_r;
  logic [COUNT_WIDTH-1:0]     pop_count_r;
  logic [FIFO_DATA_WIDTH-1:0] head_r;
  logic [FIFO_DATA_WIDTH-1:0] tail_r;

  logic                       deq_s;
  logic [2:0]                 sum_s;
  logic                       pop_s;
  logic [FIFO_DATA_WIDTH-1:0] head_next_s;
  logic [FIFO_DATA_WIDTH-1:0] tail_next_s;

  // Occupancy after this edge; deq implies occ >= 1 so the 3-bit sum cannot underflow.
  always_comb begin
    deq_s = valid_r & bus.out_ready;
    sum_s = {1'b0, occ_r} + {2'b00, inflight_r} - {2'b00, deq_s};
    pop_s = ~read_reset & read_enable & ~bus.read_fifo_empty & (sum_s <= 3'd1);
  end

  // Next head/tail contents: a capture lands in the first free slot after any dequeue.
  always_comb begin
    head_next_s = head_r;
    tail_next_s = tail_r;
    if (inflight_r) begin
      case (occ_r)
        2'd0: head_next_s = bus.read_data;
        2'd1: begin
          if (deq_s) begin
            head_next_s = bus.read_data;
          end else begin
            tail_next_s = bus.read_data;
          end
        end
        2'd2: begin
          head_next_s = tail_r;
          tail_next_s = bus.read_data;
        end
        default: begin
          head_next_s = head_r;
          tail_next_s = tail_r;
        end
      endcase
    end else if (deq_s && (occ_r == 2'd2)) begin
      head_next_s = tail_r;
    end else begin
      head_next_s = head_r;
    end
  end

  // Control state and counter; a word in flight at reset is dropped by clearing inflight.
  always_ff @(posedge read_clk) begin
    if (read_reset) begin
      occ_r       <= 2'd0;
      inflight_r  <= 1'b0;
      valid_r     <= 1'b0;
      pop_count_r <= {COUNT_WIDTH{1'b0}};
    end else begin
      occ_r       <= sum_s[1:0];
      inflight_r  <= pop_s;
      valid_r     <= (sum_s != 3'd0);
      pop_count_r <= pop_count_r + {{(COUNT_WIDTH-1){1'b0}}, pop_s};
    end
  end

  // Data slots carry no reset; their contents are qualified by occ.
  always_ff @(posedge read_clk) begin
    head_r <= head_next_s;
    tail_r <= tail_next_s;
  end

  assign bus.read_fifo_pop = pop_s;
  assign bus.out_valid     = valid_r;
  assign bus.out_data      = head_r;
  assign pop_count         = pop_count_r;

endmodule

// File: doc/async_fifo_read_stream.md
# async_fifo_read_stream

Read-side consumer for the async FIFO, in the `read_clk` domain. It drives the FIFO read channel (`read_fifo_pop`, samples `read_data`, observes `read_fifo_empty`) and re-presents the popped words as a valid/ready stream to downstream logic. A 2-entry output buffer with pop-credit accounting sustains one word per cycle despite the FIFO's 1-cycle read latency, and no word is ever dropped or duplicated under arbitrary back-pressure. A free-running popped-word counter is provided for scoreboarding.

## Interface
Parameters:
- FIFO_DATA_WIDTH, 32, width of FIFO read data and stream data
- COUNT_WIDTH, 32, width of popped-word counter

Ports:
- read_clk  input  1  read-domain clock; only clock of the block
- read_reset  input  1  synchronous, active-high reset
- read_enable  input  1  1 = allowed to issue pops; 0 = stop popping, buffered data still drains
- read_fifo_empty  input  1  FIFO empty flag (read domain)
- read_fifo_pop  output  1  pop request to FIFO
- read_data  input  FIFO_DATA_WIDTH  FIFO read data, valid the cycle after a pop
- out_valid  output  1  stream word available
- out_ready  input  1  downstream accepts word
- out_data  output  FIFO_DATA_WIDTH  stream word (head of buffer)
- pop_count  output  COUNT_WIDTH  total pops issued since reset, wraps modulo 2^COUNT_WIDTH

## Operation
- FIFO contract: data for a pop asserted in cycle N appears on `read_data` in cycle N+1 and is captured at the end of N+1. The block never pops while `read_fifo_empty`=1.
- State:
  - `occ` (0..2), the number of buffered words.
  - `inflight` (0/1), registered copy of `read_fifo_pop`.
  - Two data registers forming a FIFO; head = oldest.
- `deq` = out_valid & out_ready.
- Pop rule (combinational): `read_fifo_pop` = read_enable & !read_fifo_empty & ((occ + inflight − deq) ≤ 1). Compute the sum at 3 bits to avoid underflow/overflow.
- Update every cycle:
  - occ ← occ + inflight − deq.
  - If inflight, write `read_data` to the tail slot. When occ = 0, or occ = 1 with deq, the captured word becomes the head.
  - inflight ← read_fifo_pop.
  - pop_count ← pop_count + read_fifo_pop.
- out_valid = (occ ≠ 0); out_data = head register. Both are driven straight from registers; out_data is held stable while out_valid & !out_ready.
- Simultaneous capture and dequeue with occ = 1: head ← captured word, occ stays 1.
- Simultaneous capture and dequeue with occ = 2: head ← second slot, tail ← captured word, occ stays 2.
- Invariant: occ + inflight ≤ 2 at every clock edge. Overflow is impossible by the pop rule; the bench asserts it.
- read_enable falling: no new pops from that cycle; an in-flight word is still captured and delivered.
- read_fifo_empty toggling: gates only the current-cycle pop; in-flight words are unaffected.
- Reset (any cycle, including mid-transfer): occ, inflight, and pop_count are cleared to 0 at the reset edge. A word in flight at reset is discarded (`read_data` ignored in the first post-reset cycle because inflight = 0). Data registers need no reset.

## Timing
- Reset values: read_fifo_pop = 0 (combinationally, since occ = inflight = 0 but read_enable/empty gate it; read_fifo_pop is held 0 while read_reset = 1), out_valid = 0, pop_count = 0, out_data = don't-care.
- Latency: pop in cycle N → word captured end of N+1 → out_valid = 1 in N+2, with out_data = that word.
- Throughput: with out_ready held 1 and FIFO non-empty, 1 pop and 1 dequeue per cycle in steady state.
- Back-pressure: out_ready low for K cycles leaves at most 2 buffered words. Pops stop within 1 cycle (occ + inflight reaches 2). Popping resumes the same cycle out_ready returns high.
- No combinational path from out_ready to out_valid/out_data. The combinational path out_ready → read_fifo_pop is permitted.

## Test plan
- Reset then stream: the FIFO holds 0x11, 0x22, 0x33 with out_ready = 1 → out_data 0x11/0x22/0x33 in consecutive cycles starting 2 cycles after the first pop; pop_count = 3; out_valid drops after 0x33.
- Back-pressure: 10 words queued, out_ready = 0 for 8 cycles → exactly 2 pops issued, out_data holds word 0 stable. After release, all 10 words are delivered in order with no gaps; pop_count = 10.
- Random out_ready (50%) and random read_fifo_empty over 1000 words → output sequence equals the FIFO write sequence; invariant occ + inflight ≤ 2 holds; no pop while empty.
- read_enable deasserted the cycle after a pop → that in-flight word is still delivered; no further pops; pop_count is frozen.
- Reset asserted in the cycle after a pop with 2 words buffered → out_valid = 0 and pop_count = 0 next cycle; the in-flight word never appears on out_data.
- pop_count wrap with COUNT_WIDTH = 4: 17 pops → pop_count = 1.
